// File: rtl/msrv32_store_unit_pkg.sv
// Shared definitions for the store unit: FSM states, store size codes and AHB HTRANS codes.
package msrv32_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } store_state_t;

  typedef enum logic [1:0] {
    SZ_SB = 2'b00,
    SZ_SH = 2'b01,
    SZ_SW = 2'b10
  } store_size_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  // Size code 2'b11 falls through to the word rule.
  function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_SB:   return 1'b0;
      SZ_SH:   return lsb[0];
      default: return (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/msrv32_store_unit_align.sv
// Combinational lane steering: replicates store data across byte lanes and builds the write mask.
module msrv32_store_align
  import msrv32_store_unit_pkg::*;
(
  input  logic [1:0]  store_size_in,
  input  logic [1:0]  addr_lsb_in,
  input  logic [31:0] rs2_in,
  output logic [31:0] lane_data_out,
  output logic [3:0]  wr_mask_out,
  output logic        misaligned_out
);

  always_comb begin
    lane_data_out  = '0;
    wr_mask_out    = '0;
    misaligned_out = store_misaligned(store_size_in, addr_lsb_in);
    case (store_size_in)
      SZ_SB: begin
        lane_data_out = {4{rs2_in[7:0]}};
        wr_mask_out   = 4'b0001 << addr_lsb_in;
      end
      SZ_SH: begin
        lane_data_out = {2{rs2_in[15:0]}};
        wr_mask_out   = addr_lsb_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data_out = rs2_in;
        wr_mask_out   = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_store_unit.sv
// Store unit: turns an execute-stage store into a single AHB write (address phase, data phase).
module msrv32_store_unit
  import msrv32_store_unit_pkg::*;
(
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  store_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        stall_out,
  output logic        st_done_out,
  output logic        st_err_out,
  output logic        st_misaligned_out
);

  store_state_t r_state;
  htrans_t      r_htrans;
  logic [31:0]  r_addr;
  logic [31:0]  r_data;
  logic [3:0]   r_mask;
  logic         r_wr_req;
  logic         r_done;
  logic         r_err;
  logic         r_misaligned;

  logic [31:0]  w_lane_data;
  logic [3:0]   w_mask;
  logic         w_misaligned;
  logic         w_accept;

  msrv32_store_align u_align (
    .store_size_in  (store_size_in),
    .addr_lsb_in    (iadder_in[1:0]),
    .rs2_in         (rs2_in),
    .lane_data_out  (w_lane_data),
    .wr_mask_out    (w_mask),
    .misaligned_out (w_misaligned)
  );

  assign w_accept = (r_state == ST_IDLE) && mem_wr_req_in && !w_misaligned;

  // Stall rises combinationally in the request cycle so the pipeline holds before the FSM leaves IDLE.
  assign stall_out = !ms_riscv32_mp_rst_in && ((r_state != ST_IDLE) || w_accept);

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state      <= ST_IDLE;
      r_htrans     <= HTRANS_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_wr_req     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_wr_req_in) begin
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
            end else begin
              r_addr   <= {iadder_in[31:2], 2'b00};
              r_data   <= w_lane_data;
              r_mask   <= w_mask;
              r_wr_req <= 1'b1;
              r_htrans <= HTRANS_NONSEQ;
              r_state  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (ahb_ready_in) begin
            r_wr_req <= 1'b0;
            r_htrans <= HTRANS_IDLE;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (ahb_ready_in) begin
            if (ahb_resp_in) r_err <= 1'b1;
            else             r_done <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_wr_req <= 1'b0;
          r_htrans <= HTRANS_IDLE;
        end
      endcase
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = r_addr;
  assign ms_riscv32_mp_dmdata_out    = r_data;
  assign ms_riscv32_mp_dmwr_mask_out = r_mask;
  assign ms_riscv32_mp_dmwr_req_out  = r_wr_req;
  assign ahb_htrans_out              = r_htrans;
  assign st_done_out                 = r_done;
  assign st_err_out                  = r_err;
  assign st_misaligned_out           = r_misaligned;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Scoreboard bench for msrv32_store_unit: driver pushes expected outcomes, negedge monitor checks them.
module tb_msrv32_store_unit;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_MIS   = 2;
  localparam int K_ABORT = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int unsigned stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_wr_req_in = 1'b0;
  logic [1:0]  store_size_in = '0;
  logic [31:0] iadder_in = '0;
  logic [31:0] rs2_in = '0;
  logic        ahb_ready_in = 1'b0;
  logic        ahb_resp_in = 1'b0;
  logic [31:0] dmaddr, dmdata;
  logic [3:0]  dmmask;
  logic        dmwr_req;
  logic [1:0]  htrans;
  logic        stall, st_done, st_err, st_mis;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  msrv32_store_unit dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .mem_wr_req_in               (mem_wr_req_in),
    .store_size_in               (store_size_in),
    .iadder_in                   (iadder_in),
    .rs2_in                      (rs2_in),
    .ahb_ready_in                (ahb_ready_in),
    .ahb_resp_in                 (ahb_resp_in),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmdata_out    (dmdata),
    .ms_riscv32_mp_dmwr_mask_out (dmmask),
    .ms_riscv32_mp_dmwr_req_out  (dmwr_req),
    .ahb_htrans_out              (htrans),
    .stall_out                   (stall),
    .st_done_out                 (st_done),
    .st_err_out                  (st_err),
    .st_misaligned_out           (st_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lane data by multiplication-replication, mask by position arithmetic.
  function automatic exp_t model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int unsigned off;
    off     = a % 4;
    e.kind  = K_DONE;
    e.addr  = a - off;
    e.stall = 0;
    case (sz)
      2'd0: begin
        e.data = (d % 256) * 32'h01010101;
        e.mask = 4'(1 << off);
      end
      2'd1: begin
        e.data = (d % 65536) * 32'h00010001;
        e.mask = (off >= 2) ? 4'hC : 4'h3;
        if (off % 2 != 0) e.kind = K_MIS;
      end
      default: begin
        e.data = d;
        e.mask = 4'hF;
        if (off != 0) e.kind = K_MIS;
      end
    endcase
    return e;
  endfunction

  function automatic logic [2:0] exp_pulse(input int kind);
    case (kind)
      K_DONE:  return 3'b100;
      K_ERR:   return 3'b010;
      K_MIS:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic scramble();
    mem_wr_req_in = 1'($urandom);
    store_size_in = 2'($urandom);
    iadder_in     = $urandom;
    rs2_in        = $urandom;
  endtask

  task automatic idle_inputs();
    mem_wr_req_in = 1'b0;
    ahb_ready_in  = 1'b0;
    ahb_resp_in   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, dmaddr, 32'h0);
    chk({tag, "_data"}, dmdata, 32'h0);
    chk({tag, "_mask"}, {28'h0, dmmask}, 32'h0);
    chk({tag, "_ctl"}, {26'h0, dmwr_req, htrans, stall, st_done, st_err}, 32'h0);
    chk({tag, "_mis"}, {31'h0, st_mis}, 32'h0);
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int unsigned aw, input int unsigned dw, input bit resp, input bit abort);
    exp_t e;
    e = model(sz, a, d);
    if (e.kind != K_MIS) begin
      e.stall = 3 + aw + dw;
      if (abort)      e.kind = K_ABORT;
      else if (resp)  e.kind = K_ERR;
    end
    exp_q.push_back(e);
    mem_wr_req_in = 1'b1;
    store_size_in = sz;
    iadder_in     = a;
    rs2_in        = d;
    ahb_ready_in  = 1'($urandom);
    ahb_resp_in   = 1'($urandom);
    @(posedge clk); #1;
    if (e.kind == K_MIS) begin
      idle_inputs();
      @(posedge clk); #1;
      return;
    end
    for (int unsigned i = 0; i < aw; i++) begin
      scramble(); ahb_ready_in = 1'b0; ahb_resp_in = 1'($urandom);
      @(posedge clk); #1;
    end
    scramble(); ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < dw; i++) begin
      scramble(); ahb_ready_in = 1'b0; ahb_resp_in = 1'($urandom);
      @(posedge clk); #1;
    end
    if (abort) begin
      scramble(); ahb_ready_in = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      return;
    end
    scramble(); ahb_ready_in = 1'b1; ahb_resp_in = resp;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  // Monitor: counts stall cycles per store, checks bus outputs during a transfer, pops on pulses.
  bit          in_xfer = 1'b0;
  int unsigned stall_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] pulses;
    pulses = {st_done, st_err, st_mis};
    if (rst) begin
      in_xfer   = 1'b0;
      stall_cnt = 0;
      if (exp_q.size() > 0 && exp_q[0].kind == K_ABORT) begin
        void'(exp_q.pop_front());
        check_reset_outputs("rst_mon");
      end
    end else begin
      if (stall) stall_cnt++;
      if (dmwr_req) in_xfer = 1'b1;
      if (in_xfer) begin
        if (exp_q.size() == 0) begin
          chk("spurious_xfer", 32'(dmwr_req), 32'h0);
        end else begin
          e = exp_q[0];
          chk("xfer_not_misaligned", 32'(e.kind == K_MIS), 32'h0);
          chk("addr", dmaddr, e.addr);
          chk("data", dmdata, e.data);
          chk("mask", {28'h0, dmmask}, {28'h0, e.mask});
          chk("htrans", {30'h0, htrans}, dmwr_req ? 32'h2 : 32'h0);
        end
      end
      if (pulses != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {29'h0, pulses}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {29'h0, pulses}, {29'h0, exp_pulse(e.kind)});
          chk("stall_cycles", stall_cnt, e.stall);
          chk("stall_at_pulse", 32'(stall), 32'h0);
          chk("wrreq_at_pulse", 32'(dmwr_req), 32'h0);
        end
        in_xfer   = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    do_store(2'b00, 32'h0000_1003, 32'h1122_33AB, 0, 0, 1'b0, 1'b0);
    do_store(2'b01, 32'h0000_2002, 32'h0000_BEEF, 0, 2, 1'b0, 1'b0);
    do_store(2'b10, 32'h0000_3001, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b0);
    do_store(2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 0, 0, 1'b1, 1'b0);
    do_store(2'b10, 32'h0000_5000, 32'hCAFE_0001, 1, 1, 1'b0, 1'b1);
    do_store(2'b00, 32'h0000_6001, 32'h0000_0077, 0, 0, 1'b0, 1'b0);
    do_store(2'b10, 32'h0000_0010, 32'h0101_0101, 1, 0, 1'b0, 1'b0);
    do_store(2'b10, 32'h0000_0014, 32'h0202_0202, 0, 1, 1'b0, 1'b0);
    do_store(2'b11, 32'h0000_7004, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
    do_store(2'b01, 32'h0000_8001, 32'h0000_5555, 0, 0, 1'b0, 1'b0);
    do_store(2'b01, 32'h0000_9000, 32'h0000_A5A5, 2, 0, 1'b0, 1'b0);
    for (int k = 0; k < 60; k++) begin
      do_store(2'($urandom), $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end
    repeat (4) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
